// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: averages and decimates an ADC stream into signed samples, then streams them out in ping-pong buffered frames
// Ports: clk, rst_n (async active-low); adc_valid/adc_channel/adc_data carry the ADC response stream
// with no backpressure; out_valid/out_ready/out_data/out_sop/out_eop form the frame stream to the FFT;
// overflow is sticky and is set when a decimated sample is dropped; clr_overflow clears it synchronously.
module adc_frame_buffer #(
  parameter int DATA_W = 12,
  parameter int CHANNEL = 0,
  parameter int DECIM_LOG2 = 2,
  parameter int FRAME_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_valid,
  input  logic [4:0]        adc_channel,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int FRAME_LEN = 1 << FRAME_LOG2;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, state_d;
  logic [ACC_W-1:0] acc, sum;
  logic [DECIM_LOG2-1:0] dcnt;
  logic [DATA_W-1:0] avg, s, rdata;
  logic [DATA_W-1:0] mem [2*FRAME_LEN];
  logic [FRAME_LOG2-1:0] wr_addr, rd_addr, raddr;
  logic [1:0] full, set_full, clr_full;
  logic s_valid, wr_bank, rd_bank, accept, wr_en, drop, hs;
  assign accept = adc_valid && adc_channel == 5'(CHANNEL);
  assign sum = acc + ACC_W'(adc_data);
  assign avg = sum[ACC_W-1:DECIM_LOG2];
  assign wr_en = s_valid && !full[wr_bank];
  assign drop = s_valid && full[wr_bank];
  assign hs = state == HOLD && out_ready;
  assign out_valid = state == HOLD;
  assign set_full = wr_en && &wr_addr ? 2'b01 << wr_bank : 2'b00;
  assign clr_full = hs && &rd_addr ? 2'b01 << rd_bank : 2'b00;
  // The read address looks one step ahead so FETCH sees the sample for the updated rd_addr
  always_comb begin
    state_d = state == IDLE ? (full[rd_bank] ? FETCH : IDLE) :
              state == FETCH ? HOLD :
              hs ? (&rd_addr ? IDLE : FETCH) : HOLD;
    raddr = hs && !(&rd_addr) ? rd_addr + 1'b1 : rd_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      dcnt <= '0;
      s <= '0;
      s_valid <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      overflow <= 1'b0;
      out_data <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
    end else begin
      if (accept) begin
        acc <= &dcnt ? '0 : sum;
        dcnt <= dcnt + 1'b1;
      end
      s_valid <= accept && &dcnt;
      // Subtracting mid-scale is just an MSB flip
      if (accept && &dcnt) s <= {~avg[DATA_W-1], avg[DATA_W-2:0]};
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
        if (&wr_addr) wr_bank <= ~wr_bank;
      end
      full <= (full | set_full) & ~clr_full;
      overflow <= drop || (overflow && !clr_overflow);
      if (state == FETCH) begin
        out_data <= rdata;
        out_sop <= rd_addr == '0;
        out_eop <= &rd_addr;
      end
      if (hs) begin
        rd_addr <= rd_addr + 1'b1;
        if (&rd_addr) rd_bank <= ~rd_bank;
      end
    end
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= s;
    rdata <= mem[{rd_bank, raddr}];
  end
endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: directed, table-driven bench for adc_frame_buffer
module tb_adc_frame_buffer;
  logic clk = 0, rst_n = 1, adc_valid = 0, out_ready = 0, clr_overflow = 0;
  logic [4:0] adc_channel = 0;
  logic [11:0] adc_data = 0;
  logic out_valid, out_sop, out_eop, overflow;
  logic [11:0] out_data;
  int checks = 0, errors = 0;
  logic [11:0] q_data[$];
  logic q_sop[$], q_eop[$];
  typedef struct {
    logic [11:0] d[4];
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[5];
  adc_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_channel(adc_channel),
    .adc_data(adc_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .overflow(overflow), .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] ch, input logic [11:0] d);
    @(posedge clk);
    #1;
    adc_valid = v;
    adc_channel = ch;
    adc_data = d;
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    out_ready = v;
  endtask
  task automatic feed(input int groups, input logic [11:0] base, input logic ramp);
    for (int i = 0; i < groups; i++)
      for (int k = 0; k < 4; k++) drive(1'b1, 5'd0, ramp ? base + 12'(i) : base);
    drive(1'b0, 5'd0, 12'd0);
  endtask
  task automatic clear_q();
    q_data.delete();
    q_sop.delete();
    q_eop.delete();
  endtask
  task automatic wait_count(input string name, input int n);
    int c = 0;
    while (q_data.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (60) @(negedge clk);
    check({name, " count"}, q_data.size(), n);
  endtask
  task automatic check_frame(input string name, input int off, input logic [11:0] first, input logic ramp);
    int bad_d = 0, bad_s = 0, bad_e = 0;
    for (int i = 0; i < 256; i++) begin
      if (off + i >= q_data.size()) begin
        bad_d++;
        continue;
      end
      if (q_data[off+i] != first + (ramp ? 12'(i) : 12'd0)) bad_d++;
      if (q_sop[off+i] != (i == 0)) bad_s++;
      if (q_eop[off+i] != (i == 255)) bad_e++;
    end
    check({name, " bad data"}, bad_d, 0);
    check({name, " bad sop"}, bad_s, 0);
    check({name, " bad eop"}, bad_e, 0);
  endtask
  initial begin
    vecs[0] = '{'{12'h000, 12'h004, 12'h008, 12'h00C}, 12'h806};
    vecs[1] = '{'{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 12'h7FF};
    vecs[2] = '{'{12'h000, 12'h000, 12'h000, 12'h000}, 12'h800};
    vecs[3] = '{'{12'h801, 12'h801, 12'h801, 12'h802}, 12'h001};
    vecs[4] = '{'{12'h000, 12'hFFF, 12'h000, 12'hFFF}, 12'hFFF};
    #1 rst_n = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) drive(1'b1, 5'(i % 2), 12'(i * 300));
    drive(1'b0, 5'd0, 12'd0);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset overflow", overflow, 0);
    check("reset out_sop", out_sop, 0);
    check("reset out_eop", out_eop, 0);
    check("reset out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1;
    clear_q();
    for (int v = 0; v < 5; v++)
      for (int k = 0; k < 4; k++) drive(1'b1, 5'd0, vecs[v].d[k]);
    feed(251, 12'h800, 1'b0);
    wait_count("arith", 256);
    for (int v = 0; v < 5; v++) check($sformatf("arith vec%0d", v), v < q_data.size() ? int'(q_data[v]) : -1, vecs[v].exp);
    check("first sop after reset", q_sop.size() > 0 ? int'(q_sop[0]) : -1, 1);
    begin
      int bad = 0;
      for (int i = 5; i < 256; i++) if (i >= q_data.size() || q_data[i] != 12'h000) bad++;
      check("arith filler", bad, 0);
    end
    clear_q();
    feed(256, 12'h800, 1'b0);
    wait_count("midscale", 256);
    check_frame("midscale", 0, 12'h000, 1'b0);
    clear_q();
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 5'd1, 12'hFFF);
      drive(1'b1, 5'd0, 12'h800);
    end
    drive(1'b0, 5'd0, 12'd0);
    wait_count("chan filter", 256);
    check_frame("chan filter", 0, 12'h000, 1'b0);
    clear_q();
    set_ready(1'b0);
    feed(256, 12'h800, 1'b1);
    feed(256, 12'h900, 1'b1);
    repeat (5) @(negedge clk);
    check("overflow before frame3", overflow, 0);
    feed(256, 12'hA00, 1'b1);
    @(negedge clk);
    check("overflow frame3", overflow, 1);
    clr_overflow = 1;
    for (int k = 0; k < 4; k++) drive(1'b1, 5'd0, 12'hFFF);
    drive(1'b0, 5'd0, 12'd0);
    @(negedge clk);
    check("overflow cleared", overflow, 0);
    @(negedge clk);
    check("overflow set beats clr", overflow, 1);
    @(negedge clk);
    check("overflow clr after set", overflow, 0);
    clr_overflow = 0;
    set_ready(1'b1);
    wait_count("ovf frames", 512);
    check_frame("ovf frame1", 0, 12'h000, 1'b1);
    check_frame("ovf frame2", 256, 12'h100, 1'b1);
    check("overflow stays clear", overflow, 0);
    clear_q();
    feed(256, 12'h7F0, 1'b0);
    wait_count("post ovf", 256);
    check_frame("post ovf", 0, 12'hFF0, 1'b0);
    check("overflow after normal frame", overflow, 0);
    clear_q();
    set_ready(1'b0);
    feed(256, 12'h800, 1'b0);
    begin
      int c = 0;
      while (!out_valid && c < 200) begin
        @(negedge clk);
        c++;
      end
    end
    check("t6 hold valid", out_valid, 1);
    drive(1'b1, 5'd0, 12'hFFF);
    drive(1'b1, 5'd0, 12'hFFF);
    drive(1'b0, 5'd0, 12'd0);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check("t6 async drop", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    clear_q();
    for (int i = 0; i < 1023; i++) drive(1'b1, 5'd0, 12'h800);
    drive(1'b0, 5'd0, 12'd0);
    repeat (600) @(negedge clk);
    check("t6 no stale data", q_data.size(), 0);
    drive(1'b1, 5'd0, 12'h800);
    drive(1'b0, 5'd0, 12'd0);
    wait_count("t6 fresh", 256);
    check_frame("t6 fresh", 0, 12'h000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
